ddr_read_arbiter: RTL and testbench

//  Shares the single DDR read channel (command + read-data FIFO) between NUM_REQ load controllers
//  (port 0 = weight buffer loader, port 1 = input feature loader by default). Each requester posts
//  one (addr,len) job; the block grants round-robin, issues the DDR command and routes the read-data

---
 rtl/ddr_read_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ddr_read_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_read_arbiter
//
// Shares one DDR read channel (command strobe + read-data FIFO) between
// NUM_REQ load controllers. Each requester posts a single (addr, len) job.
// Pending jobs are granted round-robin. The arbiter issues one DDR command per
// job, then steers the DDR read FIFO to the granted requester until the job's
// word count has been popped. After that it re-arbitrates.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_conf          1-cycle job post per requester
//   req_addr/req_len  packed per-requester job address / byte length
//   req_pending       job accepted and not yet complete
//   req_done          1-cycle completion pulse (also for zero-length posts)
//   grant             one-hot data-path owner, 0 when none
//   req_fifo_empty    per-requester empty view of the DDR FIFO
//   req_fifo_req      per-requester pop (only the granted one is honoured)
//   req_fifo_data     DDR FIFO data, shared (qualify with grant)
//   ddr_st_addr_out   DDR command address
//   ddr_len           DDR command length in bytes
//   ddr_conf          1-cycle DDR command strobe
//   ddr_fifo_empty    DDR read FIFO empty
//   ddr_fifo_req      DDR read FIFO pop
//   ddr_fifo_data     DDR read FIFO data
//   idle              no job in flight and nothing pending
// ---------------------------------------------------------------------------
module ddr_read_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int DDR_ADDR_LEN = 32,
   parameter int SINGLE_LEN   = 24,
   parameter int DATA_LEN     = 64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                req_conf,
   input  logic [NUM_REQ*DDR_ADDR_LEN-1:0]   req_addr,
   input  logic [NUM_REQ*SINGLE_LEN-1:0]     req_len,
   output logic [NUM_REQ-1:0]                req_pending,
   output logic [NUM_REQ-1:0]                req_done,
   output logic [NUM_REQ-1:0]                grant,
   output logic [NUM_REQ-1:0]                req_fifo_empty,
   input  logic [NUM_REQ-1:0]                req_fifo_req,
   output logic [DATA_LEN-1:0]               req_fifo_data,
   output logic [DDR_ADDR_LEN-1:0]           ddr_st_addr_out,
   output logic [SINGLE_LEN-1:0]             ddr_len,
   output logic                              ddr_conf,
   input  logic                              ddr_fifo_empty,
   output logic                              ddr_fifo_req,
   input  logic [DATA_LEN-1:0]               ddr_fifo_data,
   output logic                              idle
);

   localparam int BPW   = DATA_LEN / 8;
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      XFER  = 2'd2
   } state_t;

   state_t                   state;
   logic [IDX_W-1:0]         rr_ptr;
   logic [IDX_W-1:0]         gidx;
   logic [SINGLE_LEN-1:0]    cnt;

   // Per-requester job slots (data only, not reset)
   logic [DDR_ADDR_LEN-1:0]  slot_addr  [NUM_REQ];
   logic [SINGLE_LEN-1:0]    slot_len   [NUM_REQ];
   logic [SINGLE_LEN-1:0]    slot_words [NUM_REQ];

   logic [DDR_ADDR_LEN-1:0]  in_addr [NUM_REQ];
   logic [SINGLE_LEN-1:0]    in_len  [NUM_REQ];
   logic [NUM_REQ-1:0]       in_len_zero;
   logic [NUM_REQ-1:0]       accept;
   logic [NUM_REQ-1:0]       complete;
   logic [NUM_REQ-1:0]       sel_onehot;
   logic [IDX_W-1:0]         sel_idx;
   logic                     sel_vld;
   logic                     pop;
   logic                     last_pop;

   // Words needed to cover len bytes, rounding a partial last word up.
   function automatic logic [SINGLE_LEN-1:0] words_of(input logic [SINGLE_LEN-1:0] len);
      logic [SINGLE_LEN:0] sum;
      sum = {1'b0, len} + (SINGLE_LEN+1)'(BPW - 1);
      return SINGLE_LEN'(sum / (SINGLE_LEN+1)'(BPW));
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         in_addr[i]     = req_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
         in_len[i]      = req_len[i*SINGLE_LEN +: SINGLE_LEN];
         in_len_zero[i] = (in_len[i] == '0);
      end
   end

   // Round-robin pick: first pending index strictly after rr_ptr, wrapping.
   always_comb begin
      int j;
      sel_vld    = 1'b0;
      sel_idx    = '0;
      sel_onehot = '0;
      j          = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!sel_vld && req_pending[IDX_W'(j)]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(j);
         end
      end
      sel_onehot[sel_idx] = sel_vld;
   end

   // Data path steering; only the granted requester sees the FIFO in XFER.
   always_comb begin
      pop            = (state == XFER) && req_fifo_req[gidx] && !ddr_fifo_empty;
      last_pop       = pop && (cnt == slot_words[gidx] - SINGLE_LEN'(1));
      complete       = '0;
      complete[gidx] = last_pop;
      req_fifo_empty = '1;
      if (state == XFER) req_fifo_empty[gidx] = ddr_fifo_empty;
      // A post on the completion cycle of the same requester is accepted.
      accept         = req_conf & (~req_pending | complete);
   end

   assign ddr_fifo_req  = pop;
   assign req_fifo_data = ddr_fifo_data;
   assign idle          = (state == IDLE) && (req_pending == '0);

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i] && !in_len_zero[i]) begin
            slot_addr[i]  <= in_addr[i];
            slot_len[i]   <= in_len[i];
            slot_words[i] <= words_of(in_len[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         req_pending     <= '0;
         req_done        <= '0;
         grant           <= '0;
         ddr_conf        <= 1'b0;
         ddr_st_addr_out <= '0;
         ddr_len         <= '0;
         rr_ptr          <= IDX_W'(NUM_REQ - 1);
         gidx            <= '0;
         cnt             <= '0;
      end else begin
         ddr_conf <= 1'b0;
         // Set wins over clear so a post on the done cycle is kept.
         req_pending <= (req_pending & ~complete) | (accept & ~in_len_zero);
         req_done    <= complete | (accept & in_len_zero);

         case (state)
            IDLE: begin
               if (sel_vld) begin
                  grant           <= sel_onehot;
                  gidx            <= sel_idx;
                  ddr_st_addr_out <= slot_addr[sel_idx];
                  ddr_len         <= slot_len[sel_idx];
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               ddr_conf <= 1'b1;
               cnt      <= '0;
               state    <= XFER;
            end
            XFER: begin
               if (pop) begin
                  cnt <= cnt + SINGLE_LEN'(1);
                  if (last_pop) begin
                     rr_ptr <= gidx;
                     grant  <= '0;
                     state  <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_read_arbiter
//
// Directed scenarios followed by a randomized phase. A job-level reference
// model tracks pending jobs, the round-robin pointer, the owner of the data
// path and the words each job still needs. Every cycle the DUT outputs are
// compared against that model.
// ---------------------------------------------------------------------------
module tb_ddr_read_arbiter;

   localparam int NR  = 2;
   localparam int AW  = 32;
   localparam int LW  = 24;
   localparam int DW  = 64;
   localparam int BPW = DW / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_conf;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*LW-1:0]  req_len;
   logic [NR-1:0]     req_pending;
   logic [NR-1:0]     req_done;
   logic [NR-1:0]     grant;
   logic [NR-1:0]     req_fifo_empty;
   logic [NR-1:0]     req_fifo_req;
   logic [DW-1:0]     req_fifo_data;
   logic [AW-1:0]     ddr_st_addr_out;
   logic [LW-1:0]     ddr_len;
   logic              ddr_conf;
   logic              ddr_fifo_empty;
   logic              ddr_fifo_req;
   logic [DW-1:0]     ddr_fifo_data;
   logic              idle;

   ddr_read_arbiter #(
      .NUM_REQ(NR), .DDR_ADDR_LEN(AW), .SINGLE_LEN(LW), .DATA_LEN(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_conf(req_conf), .req_addr(req_addr), .req_len(req_len),
      .req_pending(req_pending), .req_done(req_done), .grant(grant),
      .req_fifo_empty(req_fifo_empty), .req_fifo_req(req_fifo_req),
      .req_fifo_data(req_fifo_data),
      .ddr_st_addr_out(ddr_st_addr_out), .ddr_len(ddr_len), .ddr_conf(ddr_conf),
      .ddr_fifo_empty(ddr_fifo_empty), .ddr_fifo_req(ddr_fifo_req),
      .ddr_fifo_data(ddr_fifo_data), .idle(idle)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [NR-1:0] m_pend;
   logic [NR-1:0] done_exp;
   logic [AW-1:0] m_addr [NR];
   logic [LW-1:0] m_len  [NR];
   int            m_words[NR];
   int            m_rr, owner, nxt, dec_cd, m_pops;
   bit            free;

   // Stimulus
   logic [NR-1:0] st_conf, st_pop;
   logic [AW-1:0] st_addr [NR];
   logic [LW-1:0] st_len  [NR];
   bit            st_empty, st_rst, repost_mode;
   logic [DW-1:0] seq;

   // Statistics
   int            cyc, n_conf, n_pop, conf_cyc, post_cyc;
   int            n_done[NR];
   logic [AW-1:0] last_conf_addr;
   int            glog[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int arb(input logic [NR-1:0] p, input int rr);
      int j;
      for (int k = 1; k <= NR; k++) begin
         j = (rr + k) % NR;
         if (p[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_pend   = '0;
      done_exp = '0;
      m_rr     = NR - 1;
      owner    = -1;
      nxt      = -1;
      dec_cd   = 0;
      free     = 1'b1;
      m_pops   = 0;
   endtask

   // Registered-output checks, sampled just after the clock edge.
   task automatic sample_regs();
      bit            conf_exp;
      logic [NR-1:0] g_exp;
      conf_exp = 1'b0;
      if (dec_cd > 0) begin
         dec_cd--;
         if (dec_cd == 0) begin
            conf_exp = 1'b1;
            owner    = nxt;
            m_pops   = 0;
         end
      end
      chk("ddr_conf", ddr_conf, conf_exp);
      if (ddr_conf === 1'b1) begin
         n_conf++;
         last_conf_addr = ddr_st_addr_out;
         conf_cyc       = cyc;
      end
      if (conf_exp) begin
         chk("ddr_addr", ddr_st_addr_out, m_addr[owner]);
         chk("ddr_len", ddr_len, m_len[owner]);
         glog.push_back(owner);
      end
      g_exp = '0;
      if (owner >= 0) g_exp[owner] = 1'b1;
      else if (dec_cd == 1) g_exp[nxt] = 1'b1;
      chk("grant", grant, g_exp);
      chk("req_pending", req_pending, m_pend);
      chk("req_done", req_done, done_exp);
      chk("idle", idle, (m_pend == '0));
      for (int i = 0; i < NR; i++) if (req_done[i] === 1'b1) n_done[i]++;
      if (free && m_pend != '0) begin
         nxt    = arb(m_pend, m_rr);
         free   = 1'b0;
         dec_cd = 2;
      end
   endtask

   task automatic run_cycle();
      bit            pop_exp, comp;
      logic [NR-1:0] fe_exp;
      if (repost_mode && owner == 0 && st_pop[0] && !st_empty && m_pops == m_words[0] - 1) begin
         st_conf[0]  = 1'b1;
         st_addr[0]  = 32'h7000;
         st_len[0]   = 16;
         repost_mode = 1'b0;
      end
      rst_n          = !st_rst;
      req_conf       = st_conf;
      req_addr       = {st_addr[1], st_addr[0]};
      req_len        = {st_len[1], st_len[0]};
      req_fifo_req   = st_pop;
      ddr_fifo_empty = st_empty;
      ddr_fifo_data  = seq;
      #1;
      pop_exp = (owner >= 0) && st_pop[owner] && !st_empty;
      fe_exp  = '1;
      if (owner >= 0) fe_exp[owner] = st_empty;
      chk("ddr_fifo_req", ddr_fifo_req, pop_exp);
      chk("req_fifo_empty", req_fifo_empty, fe_exp);
      if (pop_exp) chk("req_fifo_data", req_fifo_data, seq);
      comp = 1'b0;
      if (pop_exp) comp = (m_pops + 1 == m_words[owner]);
      @(posedge clk);
      cyc++;
      done_exp = '0;
      if (st_rst) model_reset();
      else begin
         if (pop_exp) begin
            m_pops++;
            n_pop++;
            seq++;
         end
         if (comp) begin
            m_pend[owner]   = 1'b0;
            done_exp[owner] = 1'b1;
            m_rr            = owner;
            owner           = -1;
            free            = 1'b1;
         end
         for (int i = 0; i < NR; i++) begin
            if (st_conf[i] && !m_pend[i]) begin
               if (st_len[i] == '0) done_exp[i] = 1'b1;
               else begin
                  m_pend[i]  = 1'b1;
                  m_addr[i]  = st_addr[i];
                  m_len[i]   = st_len[i];
                  m_words[i] = (int'(st_len[i]) + BPW - 1) / BPW;
               end
            end
         end
      end
      st_conf = '0;
      #1;
      sample_regs();
   endtask

   task automatic run_until_idle(input int maxc, input string tag);
      int k;
      k = 0;
      while (!(m_pend == '0 && owner < 0 && dec_cd == 0 && idle === 1'b1) && k < maxc) begin
         run_cycle();
         k++;
      end
      chk({"drain_", tag}, (k < maxc), 1'b1);
   endtask

   task automatic post(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
      st_conf[i] = 1'b1;
      st_addr[i] = a;
      st_len[i]  = l;
   endtask

   task automatic do_reset();
      st_rst = 1'b1;
      st_pop = '0;
      run_cycle();
      st_rst = 1'b0;
   endtask

   initial begin
      int c0, p0, d0, d1, k;
      rst_n = 1'b0; req_conf = '0; req_addr = '0; req_len = '0;
      req_fifo_req = '0; ddr_fifo_empty = 1'b1; ddr_fifo_data = '0;
      st_conf = '0; st_pop = '0; st_empty = 1'b0; st_rst = 1'b0; repost_mode = 1'b0;
      seq = 64'h100; cyc = 0; n_conf = 0; n_pop = 0; conf_cyc = 0; post_cyc = 0;
      n_done[0] = 0; n_done[1] = 0; last_conf_addr = '0;
      for (int i = 0; i < NR; i++) begin
         st_addr[i] = '0; st_len[i] = '0; m_addr[i] = '0; m_len[i] = '0; m_words[i] = 0;
      end
      model_reset();
      @(posedge clk); @(posedge clk); #1;

      // Reset state
      do_reset();
      chk("rst_addr", ddr_st_addr_out, 0);
      chk("rst_len", ddr_len, 0);
      chk("rst_empty_view", req_fifo_empty, 2'b11);

      // Single job: 72 bytes -> 9 words, command 3 cycles after the post
      st_pop = 2'b11;
      c0 = n_conf; p0 = n_pop; d0 = n_done[0];
      post(0, 32'h1000, 72);
      post_cyc = cyc;
      run_cycle();
      run_until_idle(60, "single");
      chk("t1_conf_count", n_conf - c0, 1);
      chk("t1_latency", conf_cyc - post_cyc, 3);
      chk("t1_addr", last_conf_addr, 32'h1000);
      chk("t1_pops", n_pop - p0, 9);
      chk("t1_done", n_done[0] - d0, 1);

      // Contention and rotation
      do_reset();
      st_pop = 2'b11;
      glog.delete();
      p0 = n_pop;
      post(0, 32'h2000, 16);
      post(1, 32'h3000, 24);
      run_cycle();
      run_until_idle(60, "contend");
      chk("t2_pops", n_pop - p0, 5);
      post(0, 32'h2100, 16);
      post(1, 32'h3100, 24);
      run_cycle();
      run_until_idle(60, "rotate");
      post(0, 32'h2200, 8);
      run_cycle();
      run_until_idle(60, "solo");
      post(0, 32'h2300, 8);
      post(1, 32'h3300, 8);
      run_cycle();
      run_until_idle(60, "favour1");
      chk("t2_glog_n", glog.size(), 7);
      if (glog.size() == 7) begin
         chk("t2_g0", glog[0], 0);
         chk("t2_g1", glog[1], 1);
         chk("t2_g2", glog[2], 0);
         chk("t2_g3", glog[3], 1);
         chk("t2_g5", glog[5], 1);
         chk("t2_g6", glog[6], 0);
      end

      // Partial last word: 20 bytes -> 3 pops, later pops not forwarded
      p0 = n_pop; d1 = n_done[1];
      post(1, 32'h0A00, 20);
      run_cycle();
      run_until_idle(60, "partial");
      for (int i = 0; i < 3; i++) run_cycle();
      chk("t3_pops", n_pop - p0, 3);
      chk("t3_done", n_done[1] - d1, 1);

      // Empty toggling every cycle
      p0 = n_pop;
      post(0, 32'h0B00, 72);
      k = 0;
      run_cycle();
      while (!(m_pend == '0 && owner < 0 && dec_cd == 0) && k < 80) begin
         st_empty = !st_empty;
         run_cycle();
         k++;
      end
      st_empty = 1'b0;
      chk("t4_bound", (k < 80), 1'b1);
      chk("t4_pops", n_pop - p0, 9);

      // Zero-length post
      c0 = n_conf; d1 = n_done[1];
      post(1, 32'h0C00, 0);
      run_cycle();
      for (int i = 0; i < 4; i++) run_cycle();
      chk("t5_len0_done", n_done[1] - d1, 1);
      chk("t5_len0_noconf", n_conf - c0, 0);

      // Repost while pending is ignored
      c0 = n_conf;
      post(0, 32'h4000, 40);
      run_cycle();
      run_cycle();
      post(0, 32'h5000, 8);
      run_cycle();
      run_until_idle(60, "ignore");
      chk("t5_ign_conf", n_conf - c0, 1);
      chk("t5_ign_addr", last_conf_addr, 32'h4000);

      // Repost on the completion cycle is accepted
      c0 = n_conf; d0 = n_done[0];
      post(0, 32'h6000, 24);
      repost_mode = 1'b1;
      run_cycle();
      run_until_idle(60, "repost");
      chk("t5_rep_conf", n_conf - c0, 2);
      chk("t5_rep_addr", last_conf_addr, 32'h7000);
      chk("t5_rep_done", n_done[0] - d0, 2);

      // Reset in the middle of a transfer
      post(0, 32'h9000, 72);
      run_cycle();
      k = 0;
      while (!(owner == 0 && m_pops == 3) && k < 40) begin
         run_cycle();
         k++;
      end
      chk("t6_reach3", (k < 40), 1'b1);
      do_reset();
      chk("t6_addr", ddr_st_addr_out, 0);
      chk("t6_len", ddr_len, 0);
      chk("t6_grant", grant, 0);
      chk("t6_idle", idle, 1'b1);
      st_pop = 2'b11;
      p0 = n_pop;
      post(1, 32'h8000, 32);
      run_cycle();
      run_until_idle(60, "after_rst");
      chk("t6_pops", n_pop - p0, 4);
      chk("t6_addr2", last_conf_addr, 32'h8000);

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < NR; i++) begin
            if ($urandom_range(0, 7) == 0) post(i, $urandom, LW'($urandom_range(0, 90)));
         end
         st_pop   = NR'($urandom_range(0, 3));
         st_empty = ($urandom_range(0, 3) == 0);
         run_cycle();
      end
      st_pop = 2'b11;
      st_empty = 1'b0;
      run_until_idle(400, "random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
